// File: rtl/pipe_csel_pkg.sv
// Shared constants, stage-count derivation and per-stage payload for the
// pipelined carry-select adder.
package pipe_csel_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 4;
    localparam int DEF_BPS   = 2;
    // Payload vectors are sized for the widest supported adder; narrower
    // instances use the low WIDTH bits.
    localparam int MAX_W     = 64;

    function automatic int calc_ns(input int width, input int block, input int bps);
        return width / (block * bps);
    endfunction

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             ovf;
        logic             sub;
        logic [MAX_W-1:0] psum;
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
    } stage_t;

endpackage

// File: rtl/pipe_csel_adder_block.sv
// One BLOCK-bit carry-select slice: both carry-in hypotheses are summed in
// parallel and the real carry-in picks the result.
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             c_in,
    output logic [BLOCK-1:0] sum,
    output logic             c_out
);

    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;

    assign r0 = {1'b0, x} + {1'b0, y};
    assign r1 = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, 1'b1};

    assign {c_out, sum} = c_in ? r1 : r0;

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder with valid/ready flow control, NS stages of
// BPS slices each. Define PIPE_CSEL_SUB_EN to enable subtraction via sub.
module pipe_csel_adder
    import pipe_csel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK,
    parameter int BPS   = DEF_BPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NS = calc_ns(WIDTH, BLOCK, BPS);
    localparam int SW = BLOCK * BPS;

    stage_t           stage_p [NS];
    logic             free    [NS];
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;
    logic             sub_eff;

`ifdef PIPE_CSEL_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign ci_eff  = sub ? 1'b1 : ci;
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign ci_eff     = ci;
    assign sub_eff    = 1'b0;
`endif

    for (genvar k = 0; k < NS; k++) begin : gen_stg
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] psum_in;
        logic             cin;
        logic             vld_in;
        logic             sub_in;
        logic             cout;
        logic [SW-1:0]    ssum;
        stage_t           nxt;
        logic             unused_stage;

        // Stage k input: the raw beat for stage 0, otherwise the previous register
        if (k == 0) begin : g_src
            assign op_a    = a;
            assign op_b    = b_eff;
            assign cin     = ci_eff;
            assign vld_in  = in_valid;
            assign sub_in  = sub_eff;
            assign psum_in = '0;
        end else begin : g_src
            assign op_a    = stage_p[k-1].a[WIDTH-1:0];
            assign op_b    = stage_p[k-1].b[WIDTH-1:0];
            assign cin     = stage_p[k-1].carry;
            assign vld_in  = stage_p[k-1].valid;
            assign sub_in  = stage_p[k-1].sub;
            assign psum_in = stage_p[k-1].psum[WIDTH-1:0];
        end

        for (genvar j = 0; j < BPS; j++) begin : gen_blk
            logic c_in;
            logic c_out;
            if (j == 0) begin : g_cin
                assign c_in = cin;
            end else begin : g_cin
                assign c_in = gen_blk[j-1].c_out;
            end
            csel_block #(.BLOCK(BLOCK)) u_blk (
                .x    (op_a[(k*BPS+j)*BLOCK +: BLOCK]),
                .y    (op_b[(k*BPS+j)*BLOCK +: BLOCK]),
                .c_in (c_in),
                .sum  (ssum[j*BLOCK +: BLOCK]),
                .c_out(c_out)
            );
        end
        assign cout = gen_blk[BPS-1].c_out;

        always_comb begin
            nxt                   = '0;
            nxt.valid             = vld_in;
            nxt.carry             = cout;
            nxt.sub               = sub_in;
            nxt.a[WIDTH-1:0]      = op_a;
            nxt.b[WIDTH-1:0]      = op_b;
            nxt.psum[WIDTH-1:0]   = psum_in;
            nxt.psum[k*SW +: SW]  = ssum;
            if (k == NS - 1) begin
                nxt.ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (ssum[SW-1] != op_a[WIDTH-1]);
            end
        end

        // A stage can load when it is empty or its beat moves on this cycle
        if (k == NS - 1) begin : g_free
            assign free[k] = !stage_p[k].valid || out_ready;
        end else begin : g_free
            assign free[k] = !stage_p[k].valid || free[k+1];
        end

        // Stage k register; only the output stage clears its data on reset
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                if (k == NS - 1) stage_p[k] <= '0;
                else             stage_p[k].valid <= 1'b0;
            end else if (free[k]) begin
                if (vld_in) stage_p[k] <= nxt;
                else        stage_p[k].valid <= 1'b0;
            end
        end

        assign unused_stage = ^stage_p[k];
    end

    assign in_ready  = free[0];
    assign out_valid = stage_p[NS-1].valid;
    assign s         = stage_p[NS-1].psum[WIDTH-1:0];
    assign co        = stage_p[NS-1].carry;
    assign ovf       = stage_p[NS-1].ovf;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Directed bench for pipe_csel_adder at WIDTH=16, BLOCK=4, BPS=1 (4 stages).
module tb_pipe_csel_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        co;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    pipe_csel_adder #(.WIDTH(16), .BLOCK(4), .BPS(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: returns {ovf, co, s}
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msub);
        logic [15:0] be;
        logic        cc;
        logic [16:0] r;
        be = mb;
        cc = mci;
`ifdef PIPE_CSEL_SUB_EN
        if (msub) begin
            be = ~mb;
            cc = 1'b1;
        end
`else
        if (msub) be = mb;
`endif
        r = {1'b0, ma} + {1'b0, be} + {16'd0, cc};
        return {(ma[15] == be[15]) && (r[15] != ma[15]), r};
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = v.a; b = v.b; ci = v.ci; sub = v.sub;
        #1;
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_s"}, s, v.s);
        chk({nm, "_co"}, co, v.co);
        chk({nm, "_ovf"}, ovf, v.ovf);
        @(posedge clk); #1;
    endtask

    // Streams n beats under repeating valid/ready patterns and checks order,
    // hold-while-stalled and total count against the model.
    task automatic run_stream(input int n, input logic [15:0] in_pat, input logic [15:0] out_pat,
                              input bit consec, input string nm);
        logic [17:0] q[$];
        logic [17:0] e;
        logic [17:0] held;
        logic        hold_pending;
        int          sent;
        int          got;
        int          first_c;
        sent = 0; got = 0; first_c = -1; hold_pending = 1'b0; held = '0;
        for (int c = 0; c < 200 && got < n; c++) begin
            out_ready = out_pat[c % 16];
            if (sent < n && in_pat[c % 16]) begin
                in_valid = 1'b1;
                a   = 16'((sent + 1) * 16'h1357);
                b   = 16'(16'h9bdf ^ (sent * 16'h0f0f));
                ci  = 1'(sent & 1);
                sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_pending) begin
                chk($sformatf("%s_hold_c%0d", nm, c), {13'd0, out_valid, ovf, co, s}, {13'd0, 1'b1, held});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk($sformatf("%s_extra_beat", nm), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("%s_beat%0d", nm, got), {ovf, co, s}, e);
                end
                if (consec) begin
                    if (first_c < 0) begin
                        first_c = c;
                        chk({nm, "_first_latency"}, c, 4);
                    end else begin
                        chk($sformatf("%s_consec%0d", nm, got), c, first_c + got);
                    end
                end
                got++;
            end
            hold_pending = out_valid && !out_ready;
            held = {ovf, co, s};
            if (in_valid) begin
                if (consec) chk($sformatf("%s_in_ready%0d", nm, sent), in_ready, 1);
                if (in_ready) begin
                    q.push_back(model(a, b, ci, sub));
                    sent++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({nm, "_count"}, got, n);
    endtask

    vec_t        vt [10];
    logic [15:0] st_a [4];
    logic [15:0] st_b [4];
    logic [17:0] st_e [4];
    int          k;
    bit          seen;

    initial begin
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[6] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`ifdef PIPE_CSEL_SUB_EN
        vt[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[9] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
`else
        vt[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
        vt[9] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b0};
`endif
        st_a = '{16'h0001, 16'h00FF, 16'hF000, 16'h7FFF};
        st_b = '{16'h0002, 16'h0001, 16'h1000, 16'h7FFF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        run_stream(8, 16'hFFFF, 16'hFFFF, 1'b1, "b2b");
        run_stream(12, 16'b1011_0111_1101_1011, 16'b1100_1011_0110_1101, 1'b0, "pat");

        // Four beats fill the pipe while the consumer stalls
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_e[i] = model(st_a[i], st_b[i], 1'b0, 1'b0);
            in_valid = 1'b1; a = st_a[i]; b = st_b[i]; ci = 1'b0; sub = 1'b0;
            #1;
            chk($sformatf("stall_fill_ready%0d", i), in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        chk("stall_in_ready_low", in_ready, 0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall_hold%0d", c), {13'd0, out_valid, ovf, co, s}, {13'd0, 1'b1, st_e[0]});
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10 && k < 4; c++) begin
            #1;
            if (out_valid) begin
                chk($sformatf("stall_drain%0d", k), {ovf, co, s}, st_e[k]);
                k++;
            end
            @(posedge clk); #1;
        end
        chk("stall_drain_count", k, 4);
        #1;
        chk("stall_empty_after", out_valid, 0);

        // Reset while three beats are in flight
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        a = 16'h5555; b = 16'h6666; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #2;
        end
        chk("midrst_no_stale_beat", seen, 0);
        run_vec('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
